execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline, between the ID/EX latch and the memory stage.
- Contains the ALU, ALU control decode, branch-target adder and an iterative multiply/divide unit with HI/LO registers.
- Registers its results in an internal EX/MEM latch whose outputs drive the memory stage directly.
- Generates Stall back to IF/ID while a multi-cycle mul/div op is in progress.

---
 rtl/execute_stage_if.sv | 57 +++++
 rtl/execute_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_execute_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// The ID/EX side (master) drives operands and control. The execute stage
// (slave) returns Stall plus the latched EX/MEM fields.
// Handshake: there is no valid/ready pair. Every cycle carries one
// instruction slot. Stall=1 means the driver must hold all ID/EX fields
// unchanged on the next cycle. Flush=1 kills the slot, and EX/MEM then
// captures a bubble.
interface execute_stage_if #(
    parameter int WIDTH = 32
);
    // ID/EX fields
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic [WIDTH-1:0] SignExtImm;
    logic [WIDTH-1:0] NPC;
    logic [4:0]       Rt;
    logic [4:0]       Rd;
    logic             RegDst;
    logic             ALUSrc;
    logic [1:0]       ALUOp;
    logic [5:0]       Funct;
    logic [1:0]       WBControl_in;
    logic             MemWrite_in;
    logic             MemRead_in;
    logic             Branch_in;
    logic             Flush;

    // back-pressure to IF/ID/ID-EX
    logic             Stall;

    // EX/MEM latch
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       WriteReg;
    logic [1:0]       WBControl;
    logic             MemWrite;
    logic             MemRead;
    logic             Branch;
    logic             Zero;
    logic [WIDTH-1:0] BranchTarget;

    modport master (
        output ReadData1, ReadData2, SignExtImm, NPC, Rt, Rd, RegDst, ALUSrc,
               ALUOp, Funct, WBControl_in, MemWrite_in, MemRead_in, Branch_in,
               Flush,
        input  Stall, ALUResult, WriteData, WriteReg, WBControl, MemWrite,
               MemRead, Branch, Zero, BranchTarget
    );

    modport slave (
        input  ReadData1, ReadData2, SignExtImm, NPC, Rt, Rd, RegDst, ALUSrc,
               ALUOp, Funct, WBControl_in, MemWrite_in, MemRead_in, Branch_in,
               Flush,
        output Stall, ALUResult, WriteData, WriteReg, WBControl, MemWrite,
               MemRead, Branch, Zero, BranchTarget
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage. It contains the ALU and ALU-control decode, the branch-target
// adder, an iterative 32-step multiply/divide unit with HI/LO registers, and
// the EX/MEM pipeline latch.
// A mul/div op stalls the front end for 33 cycles: one IDLE cycle to capture
// the operands, then 32 BUSY steps. The held instruction then retires as a
// bubble in DONE.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    execute_stage_if.slave       bus,
    output logic [1:0]           fsm_state
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;

    // Mul/div working registers.
    // For a multiply, acc holds {partial, multiplier}.
    // For a divide, acc holds {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]    opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]    rs_hold;    // original rs, returned in HI on divide-by-zero
    logic                is_div;
    logic                neg_a;      // signed op and rs negative
    logic                neg_b;      // signed op and rt negative
    logic                div_zero;

    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    alu_result;
    logic                is_muldiv;
    logic                op_signed;
    logic [WIDTH-1:0]    mag_rs;
    logic [WIDTH-1:0]    mag_rt;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_diff;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_raw;
    logic [WIDTH-1:0]    rem_raw;
    logic [WIDTH-1:0]    fin_hi;
    logic [WIDTH-1:0]    fin_lo;
    logic                bubble;

    assign fsm_state = state;

    // funct 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
    assign is_muldiv = (bus.ALUOp == 2'b10) && (bus.Funct[5:2] == 4'b0110);
    assign op_signed = ~bus.Funct[0];
    assign mag_rs    = (op_signed && bus.ReadData1[WIDTH-1]) ? ('0 - bus.ReadData1) : bus.ReadData1;
    assign mag_rt    = (op_signed && bus.ReadData2[WIDTH-1]) ? ('0 - bus.ReadData2) : bus.ReadData2;

    assign op_b = bus.ALUSrc ? bus.SignExtImm : bus.ReadData2;

    // Stall starts combinationally in the capture cycle. Flush and reset
    // drop it at once.
    assign bus.Stall = rst && !bus.Flush &&
                       (((state == IDLE) && is_muldiv) || (state == BUSY));

    // Any stalled, flushed or retiring-mul/div slot enters EX/MEM as a bubble.
    assign bubble = bus.Flush || bus.Stall || (state == DONE);

    // ALU-control decode and single-cycle ALU
    always_comb begin
        alu_result = '0;
        case (bus.ALUOp)
            2'b00:   alu_result = bus.ReadData1 + op_b;
            2'b01:   alu_result = bus.ReadData1 - op_b;
            2'b10: begin
                case (bus.Funct)
                    F_ADD:   alu_result = bus.ReadData1 + op_b;
                    F_SUB:   alu_result = bus.ReadData1 - op_b;
                    F_AND:   alu_result = bus.ReadData1 & op_b;
                    F_OR:    alu_result = bus.ReadData1 | op_b;
                    F_NOR:   alu_result = ~(bus.ReadData1 | op_b);
                    F_SLT:   alu_result = {{(WIDTH-1){1'b0}},
                                           ($signed(bus.ReadData1) < $signed(op_b))};
                    F_MFHI:  alu_result = hi;
                    F_MFLO:  alu_result = lo;
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = bus.ReadData1 + op_b;
        endcase
    end

    // One shift-add or restoring-divide step, plus the sign fix applied to
    // the result of the final step
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (div_shift >= {1'b0, opnd})
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fix = (neg_a ^ neg_b) ? ('0 - acc_next) : acc_next;
        quo_raw  = acc_next[WIDTH-1:0];
        rem_raw  = acc_next[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            fin_hi = rs_hold;
            fin_lo = '1;
        end else begin
            fin_hi = neg_a ? ('0 - rem_raw) : rem_raw;
            fin_lo = (neg_a ^ neg_b) ? ('0 - quo_raw) : quo_raw;
        end
    end

    // Mul/div FSM: capture in IDLE, 32 steps in BUSY, write HI/LO entering DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opnd     <= '0;
            rs_hold  <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
        end else if (bus.Flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_muldiv) begin
                        state    <= BUSY;
                        count    <= '0;
                        is_div   <= bus.Funct[1];
                        neg_a    <= op_signed && bus.ReadData1[WIDTH-1];
                        neg_b    <= op_signed && bus.ReadData2[WIDTH-1];
                        rs_hold  <= bus.ReadData1;
                        div_zero <= (bus.ReadData2 == '0);
                        if (bus.Funct[1]) begin
                            acc  <= {{WIDTH{1'b0}}, mag_rs};
                            opnd <= mag_rt;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_rt};
                            opnd <= mag_rs;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH-1)) begin
                        state <= DONE;
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // EX/MEM pipeline latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ALUResult    <= '0;
            bus.WriteData    <= '0;
            bus.WriteReg     <= '0;
            bus.WBControl    <= '0;
            bus.MemWrite     <= 1'b0;
            bus.MemRead      <= 1'b0;
            bus.Branch       <= 1'b0;
            bus.Zero         <= 1'b0;
            bus.BranchTarget <= '0;
        end else if (bubble) begin
            bus.ALUResult    <= '0;
            bus.WriteData    <= '0;
            bus.WriteReg     <= '0;
            bus.WBControl    <= '0;
            bus.MemWrite     <= 1'b0;
            bus.MemRead      <= 1'b0;
            bus.Branch       <= 1'b0;
            bus.Zero         <= 1'b0;
            bus.BranchTarget <= '0;
        end else begin
            bus.ALUResult    <= alu_result;
            bus.WriteData    <= bus.ReadData2;
            bus.WriteReg     <= bus.RegDst ? bus.Rd : bus.Rt;
            bus.WBControl    <= bus.WBControl_in;
            bus.MemWrite     <= bus.MemWrite_in;
            bus.MemRead      <= bus.MemRead_in;
            bus.Branch       <= bus.Branch_in;
            bus.Zero         <= (alu_result == '0);
            bus.BranchTarget <= bus.NPC + (bus.SignExtImm << 2);
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard testbench for execute_stage. The driver issues one instruction
// slot per cycle and pushes the expected Stall and EX/MEM contents. The
// monitor pops each entry, checks Stall in that cycle, and checks the latch
// after the next rising edge.
module tb_execute_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_if bus();
    logic [1:0] fsm_state;

    execute_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- types / scoreboard state ----------------
    typedef struct packed {
        logic        stall;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic        mw;
        logic        mr;
        logic        br;
        logic        zero;
        logic [31:0] bt;
    } exp_t;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [4:0]  rt_f;
        logic [4:0]  rd_f;
        logic        regdst;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [1:0]  wb;
        logic        mw;
        logic        mr;
        logic        br;
    } instr_t;

    exp_t        exp_q[$];
    int          n_vec    = 0;
    int          n_fail   = 0;
    bit          mon_busy = 1'b0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    function automatic void chk(string nm, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic bit is_md(instr_t i);
        return (i.aluop == 2'b10) && (i.funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic [31:0] ref_alu(instr_t i);
        logic [31:0] b;
        b = i.alusrc ? i.imm : i.rt;
        if (i.aluop == 2'b01) return i.rs - b;
        if (i.aluop != 2'b10) return i.rs + b;
        case (i.funct)
            6'h20: return i.rs + b;
            6'h22: return i.rs - b;
            6'h24: return i.rs & b;
            6'h25: return i.rs | b;
            6'h27: return ~(i.rs | b);
            6'h2A: return ($signed(i.rs) < $signed(b)) ? 32'd1 : 32'd0;
            6'h10: return m_hi;
            6'h12: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t ref_single(instr_t i);
        exp_t e;
        e       = '0;
        e.alu   = ref_alu(i);
        e.wdata = i.rt;
        e.wreg  = i.regdst ? i.rd_f : i.rt_f;
        e.wb    = i.wb;
        e.mw    = i.mw;
        e.mr    = i.mr;
        e.br    = i.br;
        e.zero  = (e.alu == 32'd0);
        e.bt    = i.npc + (i.imm << 2);
        return e;
    endfunction

    function automatic exp_t ref_bubble(logic stall);
        exp_t e;
        e       = '0;
        e.stall = stall;
        return e;
    endfunction

    // HI/LO outcome of a mul/div, from plain 64-bit arithmetic
    task automatic ref_muldiv(input instr_t i, output logic [31:0] hi, output logic [31:0] lo);
        longint      p;
        longint      a;
        longint      b;
        logic [63:0] u;
        hi = '0;
        lo = '0;
        case (i.funct)
            6'h18: begin
                p  = longint'($signed(i.rs)) * longint'($signed(i.rt));
                u  = 64'(p);
                hi = u[63:32];
                lo = u[31:0];
            end
            6'h19: begin
                u  = {32'd0, i.rs} * {32'd0, i.rt};
                hi = u[63:32];
                lo = u[31:0];
            end
            default: begin
                if (i.rt == 32'd0) begin
                    hi = i.rs;
                    lo = 32'hFFFF_FFFF;
                end else if (i.funct == 6'h1A) begin
                    a  = longint'($signed(i.rs));
                    b  = longint'($signed(i.rt));
                    u  = 64'(a / b);
                    lo = u[31:0];
                    u  = 64'(a % b);
                    hi = u[31:0];
                end else begin
                    lo = i.rs / i.rt;
                    hi = i.rs % i.rt;
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic apply(instr_t i, logic flush);
        bus.ReadData1    = i.rs;
        bus.ReadData2    = i.rt;
        bus.SignExtImm   = i.imm;
        bus.NPC          = i.npc;
        bus.Rt           = i.rt_f;
        bus.Rd           = i.rd_f;
        bus.RegDst       = i.regdst;
        bus.ALUSrc       = i.alusrc;
        bus.ALUOp        = i.aluop;
        bus.Funct        = i.funct;
        bus.WBControl_in = i.wb;
        bus.MemWrite_in  = i.mw;
        bus.MemRead_in   = i.mr;
        bus.Branch_in    = i.br;
        bus.Flush        = flush;
    endtask

    task automatic step(exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction. A mul/div holds for 33 stall cycles plus one
    // retire cycle. flush_at names the stall cycle (0 = capture cycle) in
    // which Flush is raised; -1 means never.
    task automatic issue(instr_t i, int flush_at);
        logic [31:0] h;
        logic [31:0] l;
        if (!is_md(i)) begin
            apply(i, flush_at == 0);
            step((flush_at == 0) ? ref_bubble(1'b0) : ref_single(i));
            return;
        end
        for (int c = 0; c < 33; c++) begin
            if (c == flush_at) begin
                apply(i, 1'b1);
                step(ref_bubble(1'b0));
                return;
            end
            apply(i, 1'b0);
            step(ref_bubble(1'b1));
        end
        apply(i, 1'b0);
        step(ref_bubble(1'b0));
        ref_muldiv(i, h, l);
        m_hi = h;
        m_lo = l;
    endtask

    function automatic instr_t mk(logic [1:0] aluop, logic [5:0] funct,
                                  logic [31:0] rs, logic [31:0] rt);
        instr_t i;
        i        = '0;
        i.aluop  = aluop;
        i.funct  = funct;
        i.rs     = rs;
        i.rt     = rt;
        i.rt_f   = 5'($urandom_range(0, 31));
        i.rd_f   = 5'($urandom_range(0, 31));
        i.regdst = 1'($urandom_range(0, 1));
        i.wb     = 2'($urandom_range(0, 3));
        i.mr     = 1'($urandom_range(0, 1));
        i.npc    = $urandom & 32'hFFFF_FFFC;
        return i;
    endfunction

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || mon_busy) && g < 200) begin
            #1;
            g++;
        end
        chk("drain_timeout", 128'(g >= 200), 128'(0));
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_stall"}, 128'(bus.Stall), 128'(0));
        chk({nm, "_fsm"},   128'(fsm_state), 128'(0));
        chk({nm, "_latch"},
            {bus.ALUResult, bus.WriteData, bus.WriteReg, bus.WBControl, bus.MemWrite,
             bus.MemRead, bus.Branch, bus.Zero, bus.BranchTarget}, 128'(0));
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_busy = 1'b1;
                e = exp_q.pop_front();
                chk("stall", 128'(bus.Stall), 128'(e.stall));
                @(posedge clk);
                #2;
                act       = '0;
                act.alu   = bus.ALUResult;
                act.wdata = bus.WriteData;
                act.wreg  = bus.WriteReg;
                act.wb    = bus.WBControl;
                act.mw    = bus.MemWrite;
                act.mr    = bus.MemRead;
                act.br    = bus.Branch;
                act.zero  = bus.Zero;
                act.bt    = bus.BranchTarget;
                e.stall   = 1'b0;
                chk("exmem", 128'(act), 128'(e));
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [5:0] ftab [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h10,
                              6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h3F};

    initial begin
        instr_t i;
        instr_t nop;
        nop = '0;
        rst = 1'b0;
        apply(nop, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // wrapping add
        issue(mk(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1), -1);
        // sub to zero with branch target
        i = mk(2'b01, 6'h00, 32'd5, 32'd5);
        i.br = 1'b1; i.npc = 32'h100; i.imm = 32'h4;
        issue(i, -1);
        // signed mult then HI/LO reads
        issue(mk(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3), -1);
        issue(mk(2'b10, 6'h12, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);
        // signed divide, remainder follows dividend
        issue(mk(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2), -1);
        issue(mk(2'b10, 6'h12, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);
        // unsigned divide by zero
        issue(mk(2'b10, 6'h1B, 32'd9, 32'd0), -1);
        issue(mk(2'b10, 6'h12, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);
        // multu flushed in BUSY cycle 10: HI/LO unchanged, next op clean
        issue(mk(2'b10, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0), 11);
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h12, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), -1);
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h12, 32'd0, 32'd0), -1);

        // reset in the middle of BUSY
        i = mk(2'b10, 6'h19, 32'hDEAD_BEEF, 32'h0000_0101);
        for (int c = 0; c < 6; c++) begin
            apply(i, 1'b0);
            step(ref_bubble(1'b1));
        end
        drain();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid_busy");
        apply(nop, 1'b0);
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        rst  = 1'b1;
        m_hi = '0;
        m_lo = '0;
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h12, 32'd0, 32'd0), -1);
        issue(mk(2'b10, 6'h18, 32'h8000_0000, 32'h8000_0000), -1);
        issue(mk(2'b10, 6'h10, 32'd0, 32'd0), -1);

        // randomized mix
        for (int n = 0; n < 160; n++) begin
            int fa;
            i = mk(2'($urandom_range(0, 3)), ftab[$urandom_range(0, 13)], $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) i.rt = i.rs;
            if ($urandom_range(0, 3) == 0) i.rs = 32'($urandom_range(0, 20)) - 32'd10;
            if ($urandom_range(0, 5) == 0) i.rt = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                i.aluop = 2'b10;
                i.funct = 6'h18 + 6'($urandom_range(0, 3));
            end
            i.imm    = $urandom_range(0, 1) ? $urandom : 32'($signed(16'($urandom)));
            i.alusrc = 1'($urandom_range(0, 1));
            i.mw     = 1'($urandom_range(0, 1));
            i.br     = 1'($urandom_range(0, 1));
            fa = -1;
            if ($urandom_range(0, 9) == 0) fa = is_md(i) ? $urandom_range(0, 32) : 0;
            issue(i, fa);
            if (is_md(i) && $urandom_range(0, 1) == 1)
                issue(mk(2'b10, $urandom_range(0, 1) ? 6'h10 : 6'h12, $urandom, $urandom), -1);
        end

        apply(nop, 1'b0);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
